// File: rtl/mul_unit_if.sv
// Multiply-unit request/response bundle between the E stage (master) and mul_unit (slave).
// busy is the stall request back to the hazard unit; done/result carry the finished product.
interface mul_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] srcA;
    logic [DATA_WIDTH-1:0] srcB;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, op, srcA, srcB, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, srcA, srcB, flush,
        output busy, done, result
    );
endinterface

// File: rtl/mul_unit.sv
// Iterative sign-magnitude shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// One partial-product step per BUSY cycle; the sign is applied once on entry to DONE.
module mul_unit #(
    parameter int DATA_WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    mul_unit_if.slave  bus
);
    localparam int CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam logic [PROD_W-1:0] PROD_ONE = {{(PROD_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    state_t                nextState;
    logic                  busyC;
    logic [CNT_W-1:0]      count;
    logic [PROD_W-1:0]     acc;
    logic [PROD_W-1:0]     mcand;
    logic [PROD_W-1:0]     accNext;
    logic [PROD_W-1:0]     product;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] resultR;
    logic [DATA_WIDTH-1:0] resultNext;
    logic                  negRes;
    logic                  hiSel;
    logic                  lastStep;
    logic                  aSigned;
    logic                  bSigned;
    logic                  opHi;

    // Magnitude as an unsigned value: the most negative input maps to 2^(W-1) without overflow.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] v,
                                                        input logic isSigned);
        logic signed [DATA_WIDTH-1:0] negV;
        negV = -v;
        return (isSigned && v[DATA_WIDTH-1]) ? negV : v;
    endfunction

    function automatic logic [PROD_W-1:0] applySign(input logic [PROD_W-1:0] p, input logic neg);
        return neg ? (~p + PROD_ONE) : p;
    endfunction

    // Ops 1xx belong to the divider and fall through to MUL signedness and low-half select.
    assign opHi     = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b011);
    assign aSigned  = (bus.op != 3'b011);
    assign bSigned  = !((bus.op == 3'b010) || (bus.op == 3'b011));
    assign lastStep = (count == CNT_W'(DATA_WIDTH - 1));

    assign accNext    = acc + (mplier[0] ? mcand : '0);
    assign product    = applySign(accNext, negRes);
    assign resultNext = hiSel ? product[PROD_W-1:DATA_WIDTH] : product[DATA_WIDTH-1:0];

    assign bus.busy   = busyC;
    assign bus.done   = (state == DONE);
    assign bus.result = resultR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // busy drops in DONE so the E stage advances on the same edge that retires the product.
    always_comb begin
        nextState = state;
        busyC     = 1'b0;
        case (state)
            IDLE: begin
                busyC = bus.start;
                if (bus.start && !bus.flush) begin
                    nextState = BUSY;
                end
            end
            BUSY: begin
                busyC = 1'b1;
                if (bus.flush) begin
                    nextState = IDLE;
                end else if (lastStep) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            acc     <= '0;
            resultR <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        mcand  <= {{DATA_WIDTH{1'b0}}, magnitude(bus.srcA, aSigned)};
                        mplier <= magnitude(bus.srcB, bSigned);
                        acc    <= '0;
                        count  <= '0;
                        negRes <= (aSigned & bus.srcA[DATA_WIDTH-1]) ^ (bSigned & bus.srcB[DATA_WIDTH-1]);
                        hiSel  <= opHi;
                    end
                end
                BUSY: begin
                    if (!bus.flush) begin
                        count  <= count + CNT_W'(1);
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        if (lastStep) begin
                            acc     <= product;
                            resultR <= resultNext;
                        end else begin
                            acc <= accNext;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: vector table for products and latency, plus
// hand-written flush, reset and held-start sequences.
module tb_mul_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_unit_if #(.DATA_WIDTH(32)) bus();
    mul_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observe n cycles starting with the current one; start drops after the first edge.
    task automatic watch(input int n, output int pulses, output int firstAt,
                         output int busyCnt, output logic [31:0] res);
        pulses  = 0;
        firstAt = -1;
        busyCnt = 0;
        res     = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busyCnt++;
            if (bus.done === 1'b1) begin
                pulses++;
                if (firstAt < 0) begin
                    firstAt = c;
                    res     = bus.result;
                end
            end
            tick();
            bus.start = 1'b0;
            bus.srcA  = ~bus.srcA;
            bus.srcB  = bus.srcB + 32'h1357;
        end
    endtask

    task automatic runOp(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int pulses, firstAt, busyCnt;
        logic [31:0] res;
        bus.start = 1'b1;
        bus.op    = o;
        bus.srcA  = a;
        bus.srcB  = b;
        bus.flush = 1'b0;
        watch(40, pulses, firstAt, busyCnt, res);
        check({name, "_result"}, res, exp);
        check({name, "_doneAt"}, firstAt, 33);
        check({name, "_busyCycles"}, busyCnt, 33);
        check({name, "_pulses"}, pulses, 1);
    endtask

    initial begin
        int pulses, firstAt, busyCnt;
        int doneTimes[2];
        logic [31:0] res;
        logic [31:0] secondRes;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[3]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[4]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[5]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[6]  = '{3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[7]  = '{3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[8]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[9]  = '{3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
        vecs[10] = '{3'b010, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001};
        vecs[11] = '{3'b001, 32'h0000_0002, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[12] = '{3'b100, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
        vecs[13] = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
        vecs[14] = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        vecs[15] = '{3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 3'b000;
        bus.srcA  = '0;
        bus.srcB  = '0;
        tick();
        tick();
        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Flush in the tenth BUSY cycle.
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.srcA  = 32'd9;
        bus.srcB  = 32'd9;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_busy_during", bus.busy, 1);
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_busy_after", bus.busy, 0);
        check("flush_done_after", bus.done, 0);
        tick();
        watch(40, pulses, firstAt, busyCnt, res);
        check("flush_no_pulse", pulses, 0);
        check("flush_result_held", bus.result, vecs[15].exp);
        runOp("after_flush", 3'b000, 32'd3, 32'd5, 32'd15);

        // Flush in IDLE blocks a start in the same cycle.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 3'b000;
        bus.srcA  = 32'd2;
        bus.srcB  = 32'd2;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check("idle_flush_busy", bus.busy, 0);
        tick();
        watch(40, pulses, firstAt, busyCnt, res);
        check("idle_flush_no_pulse", pulses, 0);

        // Reset in the twentieth BUSY cycle.
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.srcA  = 32'd7;
        bus.srcB  = 32'd6;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_result", bus.result, 0);
        tick();
        watch(40, pulses, firstAt, busyCnt, res);
        check("midrst_no_pulse", pulses, 0);

        // Start held through DONE and the following IDLE cycle, then released.
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.srcA  = 32'd3;
        bus.srcB  = 32'd4;
        pulses    = 0;
        secondRes = '0;
        doneTimes[0] = -1;
        doneTimes[1] = -1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == 33) check("hold_busy_in_done", bus.busy, 0);
            if (c == 34) check("hold_busy_restart", bus.busy, 1);
            if (bus.done === 1'b1) begin
                if (pulses < 2) doneTimes[pulses] = c;
                if (pulses == 1) secondRes = bus.result;
                pulses++;
            end
            tick();
            if (c == 34) bus.start = 1'b0;
        end
        check("hold_pulses", pulses, 2);
        check("hold_first_at", doneTimes[0], 33);
        check("hold_second_at", doneTimes[1], 67);
        check("hold_second_result", secondRes, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a multiply; driven by isMulE from the E register.
REQ-005 op  input  3  funct3 of the instruction: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-006 srcA  input  DATA_WIDTH  rs1 operand (forwarded dout1E).
REQ-007 srcB  input  DATA_WIDTH  rs2 operand (forwarded dout2E).
REQ-008 flush  input  1  abort the in-flight multiply (flushE).
REQ-009 busy  output  1  stall request to the hazard unit.
REQ-010 done  output  1  one-cycle pulse; result is valid.
REQ-011 result  output  DATA_WIDTH  selected product half.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-013 IDLE with start=1 and flush=0 SHALL:
- latch |srcA|, |srcB| and the result sign per op;
- clear the 2*DATA_WIDTH accumulator;
- set count=0;
- go to BUSY.
REQ-014 Signedness: MUL and MULH treat both operands as signed; MULHSU treats srcA signed and srcB unsigned; MULHU treats both unsigned.
REQ-015 The magnitude of 0x80000000 SHALL be taken as unsigned 2^31 with no overflow.
REQ-016 Each BUSY cycle SHALL:
- perform one shift-add step on the current multiplier LSB;
- increment count.
After exactly DATA_WIDTH BUSY cycles the FSM SHALL go to DONE.
REQ-017 On entry to DONE the 64-bit product SHALL be two's-complement negated if the sign bit is set.
REQ-018 In DONE:
- result = product[31:0] for MUL;
- result = product[63:32] for MULH, MULHSU and MULHU;
- done=1.
The FSM SHALL go to IDLE on the next cycle.
REQ-019 op values 1xx SHALL be treated as MUL (reserved for the divide unit; never started).
REQ-020 busy SHALL be combinational:
- 1 in BUSY;
- 1 in IDLE when start=1;
- 0 in DONE (the E stage advances on that edge).
REQ-021 Latency: start seen in IDLE at cycle T gives done=1 at cycle T+DATA_WIDTH+1; busy is high for cycles T..T+DATA_WIDTH.
REQ-022 DONE SHALL ignore start, so the same instruction is not restarted.
REQ-023 result SHALL hold its last value until the next DONE.
REQ-024 flush=1 in BUSY SHALL force IDLE on the next edge with no done pulse.
REQ-025 flush=1 in IDLE SHALL block a start in the same cycle.
REQ-026 flush in DONE SHALL not suppress the done pulse; the consumer discards it.
REQ-027 Operands SHALL be sampled only at the start edge; srcA and srcB changes during BUSY have no effect.

Reset
REQ-028 rst=1 SHALL, on the next edge:
- set state=IDLE, count=0, accumulator=0, result=0, done=0;
- with start=0, give busy=0.
REQ-029 rst SHALL take priority over flush and start.
REQ-030 rst asserted mid-BUSY SHALL abort the operation with no done pulse.

Verification
REQ-031 MUL srcA=7, srcB=6, start at T -> busy=1 for T..T+32; done=1 at T+33 with result=42.
REQ-032 MULHU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE; the same operands with MUL -> 0x00000001.
REQ-033 MULH -> result:
- 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000;
- 0x80000000*0x80000000 -> 0x40000000.
REQ-034 MULHSU 0xFFFFFFFF (signed -1) * 0xFFFFFFFF (unsigned) -> result=0xFFFFFFFF; MUL 0x80000000*0xFFFFFFFF -> 0x80000000.
REQ-035 Flush at BUSY cycle 10 -> no done pulse, busy=0 on the following cycle; a new start MUL 3*5 -> done with 15 after 33 cycles.
REQ-036 Reset and back-to-back cases:
- rst at BUSY cycle 20 -> state=IDLE, result=0, no done pulse;
- start held high through DONE -> exactly one done pulse, then a new operation only if start is still high in IDLE.
